// File: rtl/csr_req_master.sv
// rtl/csr_req_master.sv - CSR instruction request master: issue, wait, response, writeback, exception.
// Optional response timeout enabled by defining CSR_REQ_TIMEOUT_EN.
module csr_req_master #(
   parameter int REG_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 instr_vld,
   output logic                 instr_rdy,
   input  logic [2:0]           instr_funct3,
   input  logic [11:0]          instr_csr_addr,
   input  logic [4:0]           instr_rs1_idx,
   input  logic [REG_WIDTH-1:0] instr_rs1_val,
   input  logic [4:0]           instr_imm,
   input  logic [4:0]           instr_rd,
   output logic                 csr_req_en,
   output logic [1:0]           csr_req_op,
   output logic [2:0]           csr_funct3,
   output logic [4:0]           csr_imm,
   output logic [REG_WIDTH-1:0] rs1_val,
   output logic [11:0]          csr_req_addr,
   input  logic [31:0]          csr_req_rdata,
   input  logic                 csr_req_rvalid,
   input  logic [2:0]           csr_act_rsp,
   output logic                 csr_rrsp,
   output logic                 wb_vld,
   input  logic                 wb_rdy,
   output logic [4:0]           wb_rd,
   output logic [REG_WIDTH-1:0] wb_data,
   output logic                 excp_vld,
   output logic [1:0]           excp_cause
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      RSP  = 3'd3,
      WB   = 3'd4,
      EXCP = 3'd5
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       accept;
   logic       illegal;
   logic       sample;
   logic       timeout;
   logic [1:0] op_dec;

   assign accept  = instr_vld & instr_rdy;
   assign illegal = (instr_funct3[1:0] == 2'b00);
   assign sample  = ((state == REQ) || (state == WAIT)) && csr_req_rvalid;

`ifdef CSR_REQ_TIMEOUT_EN
   logic [7:0] wait_cnt;

   assign timeout = (state == WAIT) && !csr_req_rvalid &&
                    (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= 8'd0;
      else if (state == WAIT)
         wait_cnt <= wait_cnt + 8'd1;
      else
         wait_cnt <= 8'd0;
   end
`else
   assign timeout = 1'b0;
`endif

   // Read is skipped only for CSRRW/CSRRWI to x0; write is skipped for set/clear with a zero mask source.
   always_comb begin
      op_dec = 2'b11;
      if ((instr_funct3[1:0] == 2'b01) && (instr_rd == 5'd0))
         op_dec[1] = 1'b0;
      if (instr_funct3[1] && ((!instr_funct3[2] && (instr_rs1_idx == 5'd0)) ||
                              ( instr_funct3[2] && (instr_imm == 5'd0))))
         op_dec[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      instr_rdy  = 1'b0;
      csr_req_en = 1'b0;
      csr_rrsp   = 1'b0;
      wb_vld     = 1'b0;
      excp_vld   = 1'b0;
      case (state)
         IDLE: begin
            // Gated by rst_n so ready drops the instant reset asserts.
            instr_rdy = rst_n;
            if (accept)
               state_nxt = illegal ? EXCP : REQ;
         end
         REQ, WAIT: begin
            csr_req_en = (state == REQ);
            if (sample) begin
               if (csr_act_rsp[2])
                  state_nxt = EXCP;
               else if (csr_req_op[1])
                  state_nxt = RSP;
               else
                  state_nxt = IDLE;
            end else if (timeout) begin
               state_nxt = EXCP;
            end else begin
               state_nxt = WAIT;
            end
         end
         RSP: begin
            csr_rrsp  = 1'b1;
            state_nxt = (wb_rd != 5'd0) ? WB : IDLE;
         end
         WB: begin
            wb_vld = 1'b1;
            if (wb_rdy)
               state_nxt = IDLE;
         end
         EXCP: begin
            excp_vld  = 1'b1;
`ifdef CSR_REQ_TIMEOUT_EN
            // Acknowledge on timeout so a late responder drops its pending data.
            csr_rrsp  = (excp_cause == 2'b11);
`endif
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csr_req_op   <= 2'b00;
         csr_funct3   <= 3'd0;
         csr_imm      <= 5'd0;
         rs1_val      <= '0;
         csr_req_addr <= 12'd0;
         wb_rd        <= 5'd0;
         wb_data      <= '0;
         excp_cause   <= 2'b00;
      end else begin
         if (accept) begin
            csr_req_op   <= op_dec;
            csr_funct3   <= instr_funct3;
            csr_imm      <= instr_imm;
            rs1_val      <= instr_rs1_val;
            csr_req_addr <= instr_csr_addr;
            wb_rd        <= instr_rd;
            excp_cause   <= illegal ? 2'b10 : 2'b00;
         end
         if (sample) begin
            if (csr_act_rsp[2])
               excp_cause <= csr_act_rsp[1:0];
            else
               wb_data <= REG_WIDTH'(csr_req_rdata);
         end
         if (timeout)
            excp_cause <= 2'b11;
      end
   end

endmodule

// File: tb/tb_csr_req_master.sv
// tb/tb_csr_req_master.sv - Self-checking bench for csr_req_master with a cycle-level reference model.
module tb_csr_req_master;
   localparam int RW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instr_vld = 1'b0;
   logic          instr_rdy;
   logic [2:0]    instr_funct3 = 3'd0;
   logic [11:0]   instr_csr_addr = 12'd0;
   logic [4:0]    instr_rs1_idx = 5'd0;
   logic [RW-1:0] instr_rs1_val = '0;
   logic [4:0]    instr_imm = 5'd0;
   logic [4:0]    instr_rd = 5'd0;
   logic          csr_req_en;
   logic [1:0]    csr_req_op;
   logic [2:0]    csr_funct3;
   logic [4:0]    csr_imm;
   logic [RW-1:0] rs1_val;
   logic [11:0]   csr_req_addr;
   logic [31:0]   csr_req_rdata = 32'd0;
   logic          csr_req_rvalid = 1'b0;
   logic [2:0]    csr_act_rsp = 3'd0;
   logic          csr_rrsp;
   logic          wb_vld;
   logic          wb_rdy = 1'b0;
   logic [4:0]    wb_rd;
   logic [RW-1:0] wb_data;
   logic          excp_vld;
   logic [1:0]    excp_cause;

   always #5 clk = ~clk;

   csr_req_master #(.REG_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_vld(instr_vld), .instr_rdy(instr_rdy), .instr_funct3(instr_funct3),
      .instr_csr_addr(instr_csr_addr), .instr_rs1_idx(instr_rs1_idx), .instr_rs1_val(instr_rs1_val),
      .instr_imm(instr_imm), .instr_rd(instr_rd),
      .csr_req_en(csr_req_en), .csr_req_op(csr_req_op), .csr_funct3(csr_funct3), .csr_imm(csr_imm),
      .rs1_val(rs1_val), .csr_req_addr(csr_req_addr),
      .csr_req_rdata(csr_req_rdata), .csr_req_rvalid(csr_req_rvalid), .csr_act_rsp(csr_act_rsp),
      .csr_rrsp(csr_rrsp), .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_rd(wb_rd), .wb_data(wb_data),
      .excp_vld(excp_vld), .excp_cause(excp_cause)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Observed trace of one instruction; cycle 1 is the cycle after accept.
   int          en_cnt, en_first, rrsp_cnt, rrsp_first, wb_cnt, wb_first, excp_cnt, excp_first, rdy_first;
   logic [1:0]  op_seen, cause_seen;
   logic [2:0]  f3_seen;
   logic [4:0]  imm_seen, wbrd_seen;
   logic [11:0] addr_seen;
   logic [31:0] rs1v_seen, wbd_seen;
   bit          stable_ok, wb_stable_ok;

   // Expected trace from the reference model.
   int          e_en_cnt, e_rrsp_cnt, e_rrsp_first, e_wb_cnt, e_wb_first, e_excp_cnt, e_excp_first, e_rdy_first;
   logic [1:0]  e_op, e_cause;

   task automatic exec(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1i,
                       input logic [31:0] rs1v, input logic [4:0] imm, input logic [4:0] rd,
                       input int d, input logic [31:0] rdata, input logic [2:0] act, input int stall);
      en_cnt = 0; en_first = -1; rrsp_cnt = 0; rrsp_first = -1; wb_cnt = 0; wb_first = -1;
      excp_cnt = 0; excp_first = -1; rdy_first = -1; stable_ok = 1; wb_stable_ok = 1;
      @(negedge clk);
      instr_vld = 1'b1; instr_funct3 = f3; instr_csr_addr = addr; instr_rs1_idx = rs1i;
      instr_rs1_val = rs1v; instr_imm = imm; instr_rd = rd;
      csr_req_rvalid = 1'b1; csr_act_rsp = 3'b100; csr_req_rdata = $urandom; wb_rdy = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == 1) begin
            instr_vld = 1'b0; instr_funct3 = 3'($urandom); instr_csr_addr = 12'($urandom);
            instr_rs1_idx = 5'($urandom); instr_rs1_val = $urandom; instr_imm = 5'($urandom);
            instr_rd = 5'($urandom);
         end
         if (csr_req_en) begin en_cnt++; if (en_first < 0) en_first = k; end
         if (csr_rrsp) begin rrsp_cnt++; if (rrsp_first < 0) rrsp_first = k; end
         if (excp_vld) begin excp_cnt++; if (excp_first < 0) begin excp_first = k; cause_seen = excp_cause; end end
         if (wb_vld) begin
            if (wb_cnt == 0) begin wb_first = k; wbrd_seen = wb_rd; wbd_seen = wb_data; end
            else if (wb_rd !== wbrd_seen || wb_data !== wbd_seen) wb_stable_ok = 0;
            wb_cnt++;
         end
         if (k == 1) begin
            op_seen = csr_req_op; f3_seen = csr_funct3; imm_seen = csr_imm;
            addr_seen = csr_req_addr; rs1v_seen = rs1_val;
         end else if (!instr_rdy && (csr_req_op !== op_seen || csr_funct3 !== f3_seen ||
                  csr_imm !== imm_seen || csr_req_addr !== addr_seen || rs1_val !== rs1v_seen)) begin
            stable_ok = 0;
         end
         if (instr_rdy) begin
            rdy_first = k; csr_req_rvalid = 1'b0; wb_rdy = 1'b0;
            break;
         end
         csr_req_rvalid = (k == 1 + d) || (k == 2 + d);
         csr_act_rsp    = (k == 1 + d) ? act : 3'b100;
         csr_req_rdata  = (k == 1 + d) ? rdata : $urandom;
         wb_rdy         = wb_vld && (wb_cnt > stall);
      end
   endtask

   task automatic model(input logic [2:0] f3, input logic [4:0] rs1i, input logic [4:0] imm,
                        input logic [4:0] rd, input int d, input logic [2:0] act, input int stall);
      int  s;
      bit  to;
      e_op[1] = !(((f3 == 3'd1) || (f3 == 3'd5)) && rd == 5'd0);
      e_op[0] = !((((f3 == 3'd2) || (f3 == 3'd3)) && rs1i == 5'd0) ||
                  (((f3 == 3'd6) || (f3 == 3'd7)) && imm == 5'd0));
      e_rrsp_cnt = 0; e_rrsp_first = -1; e_wb_cnt = 0; e_wb_first = -1; e_excp_first = -1; e_cause = 2'b00;
      s = 1 + d;
`ifdef CSR_REQ_TIMEOUT_EN
      to = (d > TO);
`else
      to = 0;
`endif
      if (f3 == 3'd0 || f3 == 3'd4) begin
         e_en_cnt = 0; e_excp_first = 1; e_cause = 2'b10; e_rdy_first = 2;
      end else begin
         e_en_cnt = 1;
         if (to) begin
            e_excp_first = TO + 2; e_cause = 2'b11; e_rrsp_cnt = 1; e_rrsp_first = TO + 2; e_rdy_first = TO + 3;
         end else if (act[2]) begin
            e_excp_first = s + 1; e_cause = act[1:0]; e_rdy_first = s + 2;
         end else if (!e_op[1]) begin
            e_rdy_first = s + 1;
         end else begin
            e_rrsp_cnt = 1; e_rrsp_first = s + 1;
            if (rd == 5'd0) e_rdy_first = s + 2;
            else begin e_wb_first = s + 2; e_wb_cnt = stall + 1; e_rdy_first = s + 3 + stall; end
         end
      end
      e_excp_cnt = (e_excp_first > 0) ? 1 : 0;
   endtask

   task automatic test_reset();
      #3;
      n_tests++; if ({instr_rdy, csr_req_en, csr_rrsp, wb_vld, excp_vld} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes got %b exp 00000", {instr_rdy, csr_req_en, csr_rrsp, wb_vld, excp_vld}); end
      n_tests++; if ({csr_req_op, csr_funct3, csr_imm, csr_req_addr, wb_rd, excp_cause} !== '0 || rs1_val !== '0 || wb_data !== '0) begin n_fail++; $display("FAIL reset_fields got op=%b addr=%h wb_data=%h", csr_req_op, csr_req_addr, wb_data); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_tests++; if (instr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b exp 1", instr_rdy); end
   endtask

   task automatic test_rw_wb();
      exec(3'b001, 12'h3A0, 5'd1, 32'h0000_1F1F, 5'd0, 5'd5, 0, 32'h0000_00AB, 3'b000, 0);
      n_tests++; if (en_first !== 1 || en_cnt !== 1) begin n_fail++; $display("FAIL rw_en got first=%0d cnt=%0d exp 1/1", en_first, en_cnt); end
      n_tests++; if (op_seen !== 2'b11 || addr_seen !== 12'h3A0 || rs1v_seen !== 32'h1F1F) begin n_fail++; $display("FAIL rw_fields got op=%b addr=%h rs1=%h", op_seen, addr_seen, rs1v_seen); end
      n_tests++; if (rrsp_first !== 2 || rrsp_cnt !== 1) begin n_fail++; $display("FAIL rw_rrsp got first=%0d cnt=%0d exp 2/1", rrsp_first, rrsp_cnt); end
      n_tests++; if (wb_first !== 3 || wbrd_seen !== 5'd5 || wbd_seen !== 32'hAB) begin n_fail++; $display("FAIL rw_wb got first=%0d rd=%0d data=%h exp 3/5/ab", wb_first, wbrd_seen, wbd_seen); end
   endtask

   task automatic test_write_only();
      exec(3'b001, 12'h340, 5'd2, 32'h1234_5678, 5'd0, 5'd0, 0, 32'hDEAD_BEEF, 3'b000, 0);
      n_tests++; if (op_seen !== 2'b01 || en_cnt !== 1) begin n_fail++; $display("FAIL wo_op got op=%b en=%0d exp 01/1", op_seen, en_cnt); end
      n_tests++; if (rrsp_cnt !== 0 || wb_cnt !== 0 || rdy_first !== 2) begin n_fail++; $display("FAIL wo_flow got rrsp=%0d wb=%0d rdy=%0d exp 0/0/2", rrsp_cnt, wb_cnt, rdy_first); end
   endtask

   task automatic test_read_stall();
      exec(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd3, 0, 32'h5A5A_0001, 3'b000, 4);
      n_tests++; if (op_seen !== 2'b10) begin n_fail++; $display("FAIL rs_op got %b exp 10", op_seen); end
      n_tests++; if (wb_cnt !== 5 || !wb_stable_ok || wbd_seen !== 32'h5A5A_0001 || wbrd_seen !== 5'd3) begin n_fail++; $display("FAIL rs_wb got cnt=%0d stable=%0d data=%h", wb_cnt, wb_stable_ok, wbd_seen); end
   endtask

   task automatic test_exceptions();
      exec(3'b001, 12'h3A0, 5'd1, 32'h1, 5'd0, 5'd7, 2, 32'h77, 3'b100, 0);
      n_tests++; if (excp_cnt !== 1 || cause_seen !== 2'b00 || excp_first !== 4) begin n_fail++; $display("FAIL rsp_excp got cnt=%0d cause=%b at=%0d exp 1/00/4", excp_cnt, cause_seen, excp_first); end
      n_tests++; if (wb_cnt !== 0 || rrsp_cnt !== 0) begin n_fail++; $display("FAIL rsp_excp_nowb got wb=%0d rrsp=%0d exp 0/0", wb_cnt, rrsp_cnt); end
      exec(3'b100, 12'h3A0, 5'd1, 32'h1, 5'd0, 5'd7, 0, 32'h77, 3'b000, 0);
      n_tests++; if (excp_cnt !== 1 || cause_seen !== 2'b10 || en_cnt !== 0) begin n_fail++; $display("FAIL illegal got excp=%0d cause=%b en=%0d exp 1/10/0", excp_cnt, cause_seen, en_cnt); end
   endtask

   task automatic test_timeout();
`ifdef CSR_REQ_TIMEOUT_EN
      exec(3'b011, 12'h305, 5'd4, 32'h8, 5'd0, 5'd9, TO + 5, 32'h1, 3'b000, 0);
      n_tests++; if (excp_first !== TO + 2 || cause_seen !== 2'b11 || excp_cnt !== 1) begin n_fail++; $display("FAIL timeout got at=%0d cause=%b exp %0d/11", excp_first, cause_seen, TO + 2); end
      n_tests++; if (rrsp_first !== TO + 2 || rrsp_cnt !== 1 || wb_cnt !== 0) begin n_fail++; $display("FAIL timeout_rrsp got at=%0d cnt=%0d wb=%0d", rrsp_first, rrsp_cnt, wb_cnt); end
`else
      exec(3'b011, 12'h305, 5'd4, 32'h8, 5'd0, 5'd9, 40, 32'h0BAD_F00D, 3'b000, 0);
      n_tests++; if (excp_cnt !== 0 || rrsp_first !== 42) begin n_fail++; $display("FAIL long_wait got excp=%0d rrsp_at=%0d exp 0/42", excp_cnt, rrsp_first); end
      n_tests++; if (wb_first !== 43 || wbd_seen !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL long_wait_wb got at=%0d data=%h", wb_first, wbd_seen); end
`endif
   endtask

   task automatic test_reset_mid();
      bit bad;
      @(negedge clk);
      instr_vld = 1'b1; instr_funct3 = 3'b010; instr_csr_addr = 12'h3B0; instr_rs1_idx = 5'd6;
      instr_rs1_val = 32'hCAFE; instr_rd = 5'd4; csr_req_rvalid = 1'b0;
      @(negedge clk); instr_vld = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (instr_rdy !== 1'b0 || csr_req_en !== 1'b0) begin n_fail++; $display("FAIL mid_wait got rdy=%b en=%b exp 0/0", instr_rdy, csr_req_en); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if ({instr_rdy, csr_req_en, csr_rrsp, wb_vld, excp_vld, csr_req_op} !== '0 || csr_req_addr !== '0 || rs1_val !== '0) begin n_fail++; $display("FAIL mid_reset got strobes=%b addr=%h rs1=%h", {instr_rdy, csr_req_en, csr_rrsp, wb_vld, excp_vld}, csr_req_addr, rs1_val); end
      @(negedge clk); rst_n = 1'b1;
      csr_req_rvalid = 1'b1; csr_act_rsp = 3'b101; csr_req_rdata = 32'h1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (wb_vld || excp_vld || csr_rrsp || !instr_rdy) bad = 1;
      end
      csr_req_rvalid = 1'b0; csr_act_rsp = 3'b000;
      n_tests++; if (bad) begin n_fail++; $display("FAIL post_reset got stray activity exp idle"); end
   endtask

   task automatic test_random();
      logic [2:0] f3, act; logic [4:0] rs1i, imm, rd; logic [31:0] rdata, rs1v; logic [11:0] addr;
      int d, stall;
      for (int i = 0; i < 60; i++) begin
         f3 = 3'($urandom); addr = 12'($urandom); rs1v = $urandom; rdata = $urandom;
         rs1i = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
         imm  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
         rd   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
         act  = ($urandom_range(0, 3) == 0) ? {1'b1, 2'($urandom)} : 3'($urandom_range(0, 3));
         d = $urandom_range(0, 5); stall = $urandom_range(0, 3);
         model(f3, rs1i, imm, rd, d, act, stall);
         exec(f3, addr, rs1i, rs1v, imm, rd, d, rdata, act, stall);
         n_tests++; if (en_cnt !== e_en_cnt) begin n_fail++; $display("FAIL rnd%0d en_cnt got %0d exp %0d", i, en_cnt, e_en_cnt); end
         n_tests++; if (rdy_first !== e_rdy_first) begin n_fail++; $display("FAIL rnd%0d rdy_at got %0d exp %0d", i, rdy_first, e_rdy_first); end
         n_tests++; if (rrsp_cnt !== e_rrsp_cnt || rrsp_first !== e_rrsp_first) begin n_fail++; $display("FAIL rnd%0d rrsp got %0d@%0d exp %0d@%0d", i, rrsp_cnt, rrsp_first, e_rrsp_cnt, e_rrsp_first); end
         n_tests++; if (wb_cnt !== e_wb_cnt || wb_first !== e_wb_first) begin n_fail++; $display("FAIL rnd%0d wb got %0d@%0d exp %0d@%0d", i, wb_cnt, wb_first, e_wb_cnt, e_wb_first); end
         n_tests++; if (excp_cnt !== e_excp_cnt || excp_first !== e_excp_first) begin n_fail++; $display("FAIL rnd%0d excp got %0d@%0d exp %0d@%0d", i, excp_cnt, excp_first, e_excp_cnt, e_excp_first); end
         if (e_excp_cnt == 1) begin
            n_tests++; if (cause_seen !== e_cause) begin n_fail++; $display("FAIL rnd%0d cause got %b exp %b", i, cause_seen, e_cause); end
         end
         if (e_en_cnt == 1) begin
            n_tests++; if (en_first !== 1 || op_seen !== e_op) begin n_fail++; $display("FAIL rnd%0d req got at=%0d op=%b exp 1/%b", i, en_first, op_seen, e_op); end
            n_tests++; if (addr_seen !== addr || f3_seen !== f3 || imm_seen !== imm || rs1v_seen !== rs1v || !stable_ok) begin n_fail++; $display("FAIL rnd%0d fwd got addr=%h f3=%b imm=%0d rs1=%h stable=%0d", i, addr_seen, f3_seen, imm_seen, rs1v_seen, stable_ok); end
         end
         if (e_wb_cnt > 0) begin
            n_tests++; if (wbd_seen !== rdata || wbrd_seen !== rd || !wb_stable_ok) begin n_fail++; $display("FAIL rnd%0d wb_data got rd=%0d data=%h exp rd=%0d data=%h", i, wbrd_seen, wbd_seen, rd, rdata); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rw_wb();
      test_write_only();
      test_read_stall();
      test_exceptions();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule

// File: doc/csr_req_master.md
CSR_REQ_MASTER -- requirements
Module: csr_req_master

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, meaning operand/read-data width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning cycles to wait for csr_req_rvalid before abort (range 1..255).
REQ-003 SHALL have ports, one clock and async active-low reset:
 clk  input  1  the only clock.
 rst_n  input  1  asynchronous active-low reset.
 instr_vld  input  1  CSR instruction offered.
 instr_rdy  output  1  block can accept.
 instr_funct3  input  3  CSR funct3.
 instr_csr_addr  input  12  CSR address.
 instr_rs1_idx  input  5  rs1 index.
 instr_rs1_val  input  REG_WIDTH  rs1 value.
 instr_imm  input  5  zimm.
 instr_rd  input  5  rd index.
 csr_req_en  output  1  request strobe.
 csr_req_op  output  2  bit1 = read, bit0 = write.
 csr_funct3  output  3  forwarded funct3.
 csr_imm  output  5  forwarded zimm.
 rs1_val  output  REG_WIDTH  forwarded rs1 value.
 csr_req_addr  output  12  forwarded address.
 csr_req_rdata  input  32  responder read data.
 csr_req_rvalid  input  1  responder data valid.
 csr_act_rsp  input  3  bit2 = exception, bits[1:0] = cause.
 csr_rrsp  output  1  read-response acknowledge.
 wb_vld  output  1  writeback valid.
 wb_rdy  input  1  writeback accepted.
 wb_rd  output  5  destination register.
 wb_data  output  REG_WIDTH  old CSR value.
 excp_vld  output  1  exception pulse.
 excp_cause  output  2  exception cause.

Function
REQ-004 SHALL implement FSM states IDLE, REQ, WAIT, RSP, WB and EXCP.
REQ-005 SHALL drive instr_rdy = 1 only in IDLE, and capture all instr_* fields on instr_vld & instr_rdy.
REQ-006 SHALL decode csr_req_op at capture:
- bit1 = 0 only for CSRRW/CSRRWI with rd = 0.
- bit0 = 0 only for CSRRS/CSRRC with rs1_idx = 0, or CSRRSI/CSRRCI with imm = 0.
REQ-007 SHALL treat funct3 000 or 100 as illegal: IDLE -> EXCP with cause 2'b10, no request issued.
REQ-008 SHALL assert csr_req_en for exactly one cycle, in REQ, the cycle after accept, with op, funct3, imm, rs1_val and addr held stable from capture until return to IDLE.
REQ-009 SHALL in REQ, if csr_req_rvalid = 1, sample csr_req_rdata and csr_act_rsp the same cycle; otherwise go to WAIT.
REQ-010 SHALL in WAIT, keep csr_req_en = 0 and sample on the first cycle csr_req_rvalid = 1.
REQ-011 SHALL on a sample with csr_act_rsp[2] = 1 go to EXCP with excp_cause = csr_act_rsp[1:0]; no writeback.
REQ-012 SHALL on a normal sample:
- op[1] = 1 -> RSP.
- write-only op -> IDLE.
REQ-013 SHALL assert csr_rrsp for exactly one cycle, in RSP, then go to WB if rd != 0, else IDLE.
REQ-014 SHALL in WB, hold wb_vld = 1 with wb_rd and wb_data (zero-extended rdata) stable until wb_rdy; go to IDLE on the wb_rdy cycle.
REQ-015 SHALL in EXCP, assert excp_vld for exactly one cycle, then go to IDLE.
REQ-016 SHALL give a best-case latency of accept T -> csr_req_en T+1 -> csr_rrsp T+2 -> wb_vld T+3.
REQ-017 SHALL ignore csr_req_rvalid and csr_act_rsp outside REQ/WAIT.
REQ-018 SHALL keep one instruction in flight at most; no back-to-back accept, since next accept is earliest the cycle after return to IDLE.

Reset
REQ-019 SHALL on rst_n low, immediately and asynchronously, force state IDLE and all outputs to 0, including instr_rdy, csr_req_en, csr_rrsp, wb_vld, excp_vld, data fields and counter.
REQ-020 SHALL assert instr_rdy = 1 in the first cycle after rst_n deasserts.
REQ-021 SHALL abandon any in-flight request on reset mid-operation, with no writeback and no exception reported after release.

Configuration
REQ-022 SHALL with CSR_REQ_TIMEOUT_EN defined:
- WAIT counts cycles.
- Reaching TIMEOUT_CYCLES without csr_req_rvalid -> EXCP with cause 2'b11, and a one-cycle csr_rrsp is issued in EXCP to clear any late responder state.
REQ-023 SHALL with CSR_REQ_TIMEOUT_EN undefined: WAIT waits indefinitely, no counter is present, and cause 2'b11 is never produced.

Verification
REQ-024 SHALL cover:
- CSRRW addr 0x3A0, rs1_idx 1, rs1_val 0x0000_1F1F, rd 5, responder rvalid same cycle, rdata 0xAB -> csr_req_en at T+1 with op 2'b11, csr_rrsp at T+2, wb_vld at T+3 with wb_rd 5 and wb_data 0xAB.
- CSRRW rd 0 -> op 2'b01, single csr_req_en, no csr_rrsp, no wb_vld, instr_rdy = 1 at T+2.
- CSRRS rs1_idx 0, rd 3 -> op 2'b10; wb_rdy held low 4 cycles -> wb_vld and wb_data stable for 5 cycles.
- Responder act_rsp = 3'b100 -> excp_vld one cycle with cause 2'b00, no wb_vld; funct3 100 -> excp cause 2'b10, csr_req_en never asserted.
- With CSR_REQ_TIMEOUT_EN and rvalid held 0 -> excp cause 2'b11 exactly TIMEOUT_CYCLES cycles after entering WAIT.
- rst_n low during WAIT -> all outputs 0 immediately; after release no wb_vld or excp_vld.
